// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the arbiter FSM state type.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; last_grant flips to the winner on each accepted grant.
module rr_arb2 (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic       pick,
  output logic       any
);
  logic last_q, last_d;

  always_comb begin
    any    = |req;
    // On a tie the port that did not win last time goes; otherwise the lone requester.
    pick   = (&req) ? ~last_q : req[1];
    last_d = adv ? pick : last_q;
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) last_q <= 1'b1;
    else         last_q <= last_d;
  end
endmodule

// File: rtl/ahb_rom_arbiter.sv
// Shares one AHB ROM slave between fetch (m0) and load (m1) ports; one single
// word read in flight, registered responses, error on bad HRESP or timeout.
module ahb_rom_arbiter
  import ahb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBUST,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP
);
  localparam int NP    = 2;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [NP-1:0]             req;
  logic [NP-1:0][ADDR_W-1:0] addr;
  logic                      pick, any, adv;

  assign req  = {m1_req, m1_req & 1'b0 | m0_req & 1'b0 | m1_req & 1'b0} | {1'b0, m0_req};
  assign addr = {m1_addr, m0_addr};

  rr_arb2 u_arb (
    .gclk  (HCLK),
    .grst_n(HRESETn),
    .req   (req),
    .adv   (adv),
    .pick  (pick),
    .any   (any)
  );

  arb_state_t                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      owner_q, owner_d;
  logic                      hsel_q, hsel_d;
  logic [1:0]                htrans_q, htrans_d;
  logic [ADDR_W-1:0]         haddr_q, haddr_d;
  logic [NP-1:0]             gnt_q, gnt_d;
  logic [NP-1:0]             rvalid_q, rvalid_d;
  logic [NP-1:0]             err_q, err_d;
  logic [NP-1:0][31:0]       rdata_q, rdata_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    hsel_d   = 1'b0;
    htrans_d = HTRANS_IDLE;
    haddr_d  = haddr_q;
    gnt_d    = '0;
    rvalid_d = '0;
    err_d    = '0;
    rdata_d  = '0;
    adv      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          adv           = 1'b1;
          owner_d       = pick;
          hsel_d        = 1'b1;
          htrans_d      = HTRANS_NONSEQ;
          haddr_d       = addr[pick] & ~ADDR_W'(3);
          gnt_d[pick]   = 1'b1;
          state_d       = ADDR;
        end
      end
      ADDR: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        // A ready beat wins over the timeout on the same edge.
        if (HREADY) begin
          rvalid_d[owner_q] = 1'b1;
          if (HRESP != HRESP_OKAY) err_d[owner_q]   = 1'b1;
          else                     rdata_d[owner_q] = HRDATA;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rvalid_d[owner_q] = 1'b1;
          err_d[owner_q]    = 1'b1;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      hsel_q   <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      hsel_q   <= hsel_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign HSEL      = hsel_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = 1'b0;
  assign HSIZE     = HSIZE_WORD;
  assign HBUST     = HBURST_SINGLE;
  assign HWDATA    = '0;
endmodule

// File: tb/tb_ahb_rom_arbiter.sv
// Scenario bench for ahb_rom_arbiter: wait-state/err ROM slave model plus a
// transfer-level expectation model (winner, cycle of gnt/rvalid, data).
module tb_ahb_rom_arbiter;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 8;

  logic              HCLK = 1'b0, HRESETn = 1'b1;
  logic              m0_req = 1'b0, m1_req = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic              m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              HSEL, HWRITE;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE, HBUST;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA = '0;
  logic              HREADY = 1'b0;
  logic [1:0]        HRESP = 2'b00;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] rom [256];
  int          wait_cfg = 0;
  logic [1:0]  resp_cfg = 2'b00;
  logic        exp_last;

  ahb_rom_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBUST(HBUST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // ROM slave: after an address phase, holds HREADY low for wait_cfg data
  // cycles, then one ready beat with the addressed word and resp_cfg.
  bit                addr_seen = 1'b0, busy = 1'b0;
  int                scnt = 0;
  logic [ADDR_W-1:0] saddr = '0;

  always @(negedge HCLK) begin
    addr_seen = HSEL && (HTRANS == 2'b10);
    if (addr_seen) saddr = HADDR;
  end

  always @(posedge HCLK) begin
    #1;
    if (!HRESETn) busy = 1'b0;
    else if (addr_seen) begin
      busy = 1'b1;
      scnt = wait_cfg;
    end else if (busy) begin
      if (HREADY) busy = 1'b0;
      else if (scnt > 0) scnt--;
    end
    HREADY = busy && (scnt == 0);
    HRDATA = HREADY ? rom[saddr[9:2]] : $urandom;
    HRESP  = HREADY ? resp_cfg : 2'b00;
  end

  function automatic logic [14:0] obs();
    return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, HSEL, HTRANS, HWRITE, HBUST, HSIZE, |HWDATA};
  endfunction

  function automatic logic [14:0] xo(input logic g0, input logic g1, input logic r0, input logic r1);
    logic s;
    s = g0 | g1;
    return {g0, g1, r0, r1, s, s ? 2'b10 : 2'b00, 1'b0, 3'b000, 3'b010, 1'b0};
  endfunction

  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    @(negedge HCLK);
    n_cmp++;
    if ({m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
         HSEL, HADDR, HTRANS, HWRITE, HBUST, HWDATA} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got_nonzero m0_rdata=%h HADDR=%h HSEL=%b HTRANS=%b want=all_zero",
               m0_rdata, HADDR, HSEL, HTRANS);
    end
    n_cmp++;
    if (HSIZE !== 3'b010) begin n_bad++; $display("FAIL reset_hsize got=%b want=010", HSIZE); end
    tick();
    HRESETn  = 1'b1;
    exp_last = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== xo(0, 0, 0, 0)) begin n_bad++; $display("FAIL reset_idle got=%h want=%h", obs(), xo(0, 0, 0, 0)); end
  endtask

  task automatic test_back_to_back();
    logic nw, ow;
    logic [14:0] e;
    logic [31:0] rd, xd;
    m0_req = 1'b1; m0_addr = 10'h000; m1_req = 1'b1; m1_addr = 10'h100;
    wait_cfg = 0; resp_cfg = 2'b00;
    nw = ~exp_last; ow = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      e = xo(0, 0, 0, 0);
      if (c % 3 == 1) begin
        e = xo(!nw, nw, 0, 0);
        n_cmp++;
        if (HADDR !== (nw ? 10'h100 : 10'h000)) begin
          n_bad++; $display("FAIL b2b_haddr cyc%0d got=%h want=%h", c, HADDR, nw ? 10'h100 : 10'h000);
        end
        ow = nw; exp_last = nw; nw = ~nw;
        if (c == 10) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
      if (c % 3 == 0) e = xo(0, 0, !ow, ow);
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL b2b_ctl cyc%0d got=%h want=%h", c, obs(), e); end
      if (c % 3 == 0) begin
        rd = ow ? m1_rdata : m0_rdata;
        xd = ow ? rom[64] : rom[0];
        n_cmp++;
        if (rd !== xd || (ow ? m1_err : m0_err) !== 1'b0) begin
          n_bad++; $display("FAIL b2b_data cyc%0d port%0d got=%h want=%h", c, ow, rd, xd);
        end
      end
    end
  endtask

  task automatic test_single();
    logic [14:0] e;
    m0_req = 1'b1; m0_addr = 10'h014; wait_cfg = 0; resp_cfg = 2'b00;
    for (int c = 1; c <= 3; c++) begin
      tick();
      e = (c == 1) ? xo(1, 0, 0, 0) : (c == 3) ? xo(0, 0, 1, 0) : xo(0, 0, 0, 0);
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL single_ctl cyc%0d got=%h want=%h", c, obs(), e); end
      if (c == 1) begin
        m0_req = 1'b0; exp_last = 1'b0;
        n_cmp++;
        if (HADDR !== 10'h014) begin n_bad++; $display("FAIL single_haddr got=%h want=014", HADDR); end
      end
    end
    n_cmp++;
    if (m0_rdata !== 32'hDEADBEEF || m0_err !== 1'b0) begin
      n_bad++; $display("FAIL single_data got=%h err=%b want=deadbeef err=0", m0_rdata, m0_err);
    end
  endtask

  task automatic test_align();
    logic [14:0] e;
    m1_req = 1'b1; m1_addr = 10'h3FF; wait_cfg = 1; resp_cfg = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      tick();
      e = (c == 1) ? xo(0, 1, 0, 0) : (c == 4) ? xo(0, 0, 0, 1) : xo(0, 0, 0, 0);
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL align_ctl cyc%0d got=%h want=%h", c, obs(), e); end
      if (c == 1) begin
        m1_req = 1'b0; exp_last = 1'b1;
        n_cmp++;
        if (HADDR !== 10'h3FC) begin n_bad++; $display("FAIL align_haddr got=%h want=3fc", HADDR); end
      end
    end
    n_cmp++;
    if (m1_rdata !== rom[255] || m1_err !== 1'b0) begin
      n_bad++; $display("FAIL align_data got=%h want=%h", m1_rdata, rom[255]);
    end
  endtask

  task automatic test_timeout();
    logic [14:0] e;
    int rv;
    rv = 2 + TIMEOUT;
    m0_req = 1'b1; m0_addr = 10'h020; wait_cfg = 100; resp_cfg = 2'b00;
    for (int c = 1; c <= rv; c++) begin
      tick();
      e = (c == 1) ? xo(1, 0, 0, 0) : (c == rv) ? xo(0, 0, 1, 0) : xo(0, 0, 0, 0);
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL timeout_ctl cyc%0d got=%h want=%h", c, obs(), e); end
      if (c == 1) begin m0_req = 1'b0; exp_last = 1'b0; end
    end
    n_cmp++;
    if (m0_err !== 1'b1 || m0_rdata !== 32'h0) begin
      n_bad++; $display("FAIL timeout_err got err=%b rdata=%h want err=1 rdata=0", m0_err, m0_rdata);
    end
    // Next request is issued from the rvalid cycle and must be served normally.
    m1_req = 1'b1; m1_addr = 10'h008; wait_cfg = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      e = (c == 1) ? xo(0, 1, 0, 0) : (c == 3) ? xo(0, 0, 0, 1) : xo(0, 0, 0, 0);
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL post_timeout_ctl cyc%0d got=%h want=%h", c, obs(), e); end
      if (c == 1) begin m1_req = 1'b0; exp_last = 1'b1; end
    end
    n_cmp++;
    if (m1_rdata !== rom[2] || m1_err !== 1'b0) begin
      n_bad++; $display("FAIL post_timeout_data got=%h want=%h", m1_rdata, rom[2]);
    end
  endtask

  task automatic test_hresp_err();
    logic [14:0] e;
    m1_req = 1'b1; m1_addr = 10'h044; wait_cfg = 0; resp_cfg = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      tick();
      e = (c == 1) ? xo(0, 1, 0, 0) : (c == 3) ? xo(0, 0, 0, 1) : xo(0, 0, 0, 0);
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL hresp_ctl cyc%0d got=%h want=%h", c, obs(), e); end
      if (c == 1) begin m1_req = 1'b0; exp_last = 1'b1; end
    end
    n_cmp++;
    if (m1_err !== 1'b1 || m1_rdata !== 32'h0) begin
      n_bad++; $display("FAIL hresp_err got err=%b rdata=%h want err=1 rdata=0", m1_err, m1_rdata);
    end
    resp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid_data();
    logic [14:0] e;
    m0_req = 1'b1; m0_addr = 10'h0A0; wait_cfg = 3; resp_cfg = 2'b00;
    tick();
    n_cmp++;
    if (obs() !== xo(1, 0, 0, 0)) begin n_bad++; $display("FAIL rst_mid_gnt got=%h want=%h", obs(), xo(1, 0, 0, 0)); end
    m0_req = 1'b0; exp_last = 1'b0;
    tick();
    HRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
         HSEL, HADDR, HTRANS, HWRITE, HBUST, HWDATA} !== '0 || HSIZE !== 3'b010) begin
      n_bad++; $display("FAIL rst_mid_outputs got HADDR=%h HSEL=%b HSIZE=%b want zero/010", HADDR, HSEL, HSIZE);
    end
    tick();
    HRESETn = 1'b1; exp_last = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_cmp++;
      if (obs() !== xo(0, 0, 0, 0)) begin n_bad++; $display("FAIL rst_mid_quiet cyc%0d got=%h want=%h", c, obs(), xo(0, 0, 0, 0)); end
    end
    // Both request: the restored last_grant must hand the tie to m0.
    m0_req = 1'b1; m0_addr = 10'h0C8; m1_req = 1'b1; m1_addr = 10'h010; wait_cfg = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      e = (c == 1) ? xo(1, 0, 0, 0) : (c == 3) ? xo(0, 0, 1, 0) : xo(0, 0, 0, 0);
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL rst_mid_next_ctl cyc%0d got=%h want=%h", c, obs(), e); end
      if (c == 1) begin m0_req = 1'b0; m1_req = 1'b0; exp_last = 1'b0; end
    end
    n_cmp++;
    if (m0_rdata !== rom[50] || m0_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_next_data got=%h want=%h", m0_rdata, rom[50]);
    end
  endtask

  task automatic test_random(input int n);
    logic [1:0]  rq, rsp;
    logic        win, xerr;
    logic [9:0]  a0, a1, wa;
    logic [31:0] xd, rd;
    logic [14:0] e;
    int          w, rv;
    for (int t = 0; t < n; t++) begin
      rq = 2'($urandom_range(1, 3));
      a0 = 10'($urandom); a1 = 10'($urandom);
      case ($urandom_range(0, 6))
        0, 1:    w = 0;
        2:       w = 1;
        3:       w = 2;
        4:       w = TIMEOUT - 1;
        5:       w = TIMEOUT;
        default: w = TIMEOUT + 4;
      endcase
      rsp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      win  = (rq == 2'b11) ? ~exp_last : rq[1];
      wa   = (win ? a1 : a0) & 10'h3FC;
      xerr = (w >= TIMEOUT) || (rsp != 2'b00);
      xd   = xerr ? 32'h0 : rom[wa[9:2]];
      rv   = (w < TIMEOUT) ? 3 + w : 2 + TIMEOUT;
      m0_req = rq[0]; m1_req = rq[1]; m0_addr = a0; m1_addr = a1;
      wait_cfg = w; resp_cfg = rsp;
      for (int c = 1; c <= rv; c++) begin
        tick();
        e = (c == 1) ? xo(!win, win, 0, 0) : (c == rv) ? xo(0, 0, !win, win) : xo(0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL rand%0d_ctl cyc%0d got=%h want=%h", t, c, obs(), e); end
        if (c == 1) begin
          m0_req = 1'b0; m1_req = 1'b0; exp_last = win;
          n_cmp++;
          if (HADDR !== wa) begin n_bad++; $display("FAIL rand%0d_haddr got=%h want=%h", t, HADDR, wa); end
        end
      end
      rd = win ? m1_rdata : m0_rdata;
      n_cmp++;
      if (rd !== xd || (win ? m1_err : m0_err) !== xerr) begin
        n_bad++;
        $display("FAIL rand%0d_data port%0d w=%0d got=%h err=%b want=%h err=%b",
                 t, win, w, rd, win ? m1_err : m0_err, xd, xerr);
      end
    end
    resp_cfg = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[5] = 32'hDEADBEEF;
    test_reset();
    test_back_to_back();
    test_single();
    test_align();
    test_timeout();
    test_hresp_err();
    test_reset_mid_data();
    test_random(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
